// File: rtl/llama_pkg.sv
// Shared widths, decoded-instruction bundle and scoreboard helper for the operand fetch stage.
package llama_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 2 ** REG_AW;
  localparam int OPW    = 6;

  typedef logic [OPW-1:0] op_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
    logic [XLEN-1:0]   imm;
    op_t               op;
  } instr_t;

  // A register blocks issue while its load is outstanding, unless that load retires this cycle.
  function automatic logic reg_busy(input logic [NREG-1:0]   pend,
                                    input logic [REG_AW-1:0] r,
                                    input logic              clr,
                                    input logic [REG_AW-1:0] clr_addr);
    return (r != '0) && pend[r] && !(clr && (clr_addr == r));
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand select: x0 reads zero, then EX forward, then WB forward, then regfile.
module operand_bypass
  import llama_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_addr,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   opnd
);

  always_comb begin
    opnd = rf_data;
    if (src == '0) begin
      opnd = '0;
    end else if (ex_en && (ex_addr == src)) begin
      opnd = ex_data;
    end else if (wb_en && (wb_addr == src)) begin
      opnd = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, bypass, load-use scoreboard and the registered hand-off to EX.
module operand_fetch
  import llama_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [OPW-1:0]    in_op,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [XLEN-1:0]   rf_data_a,
  input  logic [XLEN-1:0]   rf_data_b,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_fwd_addr,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              wb_is_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_imm,
  output logic [OPW-1:0]    out_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [31:0]       stall_cnt
);

  instr_t            in_instr;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [XLEN-1:0]   opnd_a;
  logic [XLEN-1:0]   opnd_b;
  logic              wb_load_clr;
  logic              hazard;
  logic              issue;

  assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_we: in_rd_we,
                      is_load: in_is_load, imm: in_imm, op: in_op};

  assign rf_addr_a   = in_instr.rs1;
  assign rf_addr_b   = in_instr.rs2;
  assign wb_load_clr = wb_en && wb_is_load;

  operand_bypass u_bypass_a (
    .src     (in_instr.rs1),
    .rf_data (rf_data_a),
    .ex_en   (ex_fwd_en),
    .ex_addr (ex_fwd_addr),
    .ex_data (ex_fwd_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .opnd    (opnd_a)
  );

  operand_bypass u_bypass_b (
    .src     (in_instr.rs2),
    .rf_data (rf_data_b),
    .ex_en   (ex_fwd_en),
    .ex_addr (ex_fwd_addr),
    .ex_data (ex_fwd_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .opnd    (opnd_b)
  );

  // rd is checked too so a younger write cannot be overwritten by an older load (WAW).
  assign hazard = reg_busy(pending, in_instr.rs1, wb_load_clr, wb_addr)
                | reg_busy(pending, in_instr.rs2, wb_load_clr, wb_addr)
                | reg_busy(pending, in_instr.rd,  wb_load_clr, wb_addr);

  // Handshake: a beat moves on a side when valid && ready at posedge. in_ready may depend
  // combinationally on out_ready; out_* stay bit-stable while out_valid && !out_ready.
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign issue    = in_valid && in_ready;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_load_clr) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (issue && in_instr.is_load && in_instr.rd_we && (in_instr.rd != '0)) begin
      pending_nxt[in_instr.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_imm     <= '0;
      out_op      <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_a       <= opnd_a;
      out_b       <= opnd_b;
      out_imm     <= in_instr.imm;
      out_op      <= in_instr.op;
      out_rd      <= in_instr.rd;
      out_rd_we   <= in_instr.rd_we;
      out_is_load <= in_instr.is_load;
    end else if (flush || out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: driver tasks push expected EX beats, a negedge monitor pops them.
module tb_operand_fetch;
  import llama_pkg::*;

  localparam int EW = 2 * XLEN + XLEN + OPW + REG_AW + 2;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
  logic              in_rd_we, in_is_load;
  logic [XLEN-1:0]   in_imm;
  logic [OPW-1:0]    in_op;
  logic [REG_AW-1:0] rf_addr_a, rf_addr_b;
  logic [XLEN-1:0]   rf_data_a, rf_data_b;
  logic              ex_fwd_en;
  logic [REG_AW-1:0] ex_fwd_addr;
  logic [XLEN-1:0]   ex_fwd_data;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              wb_is_load;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_a, out_b, out_imm;
  logic [OPW-1:0]    out_op;
  logic [REG_AW-1:0] out_rd;
  logic              out_rd_we, out_is_load;
  logic [31:0]       stall_cnt;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_imm(in_imm), .in_op(in_op),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_is_load(wb_is_load),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_op(out_op),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .stall_cnt(stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [EW-1:0] pack(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                         input logic [XLEN-1:0] imm, input logic [OPW-1:0] op,
                                         input logic [REG_AW-1:0] rd, input logic rd_we,
                                         input logic is_load);
    return {a, b, imm, op, rd, rd_we, is_load};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                           input logic [REG_AW-1:0] rd, input logic rd_we, input logic is_load,
                           input logic [XLEN-1:0] imm, input logic [OPW-1:0] op,
                           input logic [XLEN-1:0] rfa, input logic [XLEN-1:0] rfb);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = rd_we; in_is_load = is_load;
    in_imm = imm; in_op = op; rf_data_a = rfa; rf_data_b = rfb;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic [REG_AW-1:0] rd, input logic rd_we, input logic is_load,
                       input logic [XLEN-1:0] imm, input logic [OPW-1:0] op,
                       input logic [XLEN-1:0] rfa, input logic [XLEN-1:0] rfb,
                       input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
    logic got;
    got = 1'b0;
    set_instr(rs1, rs2, rd, rd_we, is_load, imm, op, rfa, rfb);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(pack(ea, eb, imm, op, rd, rd_we, is_load));
        got = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    check("issue_accepted", {127'd0, got}, 128'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected act=beat a=%0h exp=none", out_a);
      end else begin
        check("out_beat", {19'd0, pack(out_a, out_b, out_imm, out_op, out_rd, out_rd_we, out_is_load)},
              {19'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_instr('0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_is_load = 1'b0;
    step();
    step();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_a", {96'd0, out_a}, 128'd0);
    check("rst_stall_cnt", {96'd0, stall_cnt}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;
    step();

    // Basic issue, 1-cycle latency
    issue(5'd3, 5'd4, 5'd1, 1'b1, 1'b0, 32'h100, 6'd5, 32'd10, 32'd20, 32'd10, 32'd20);
    check("lat_out_valid", {127'd0, out_valid}, 128'd1);

    // Bypass priority
    ex_fwd_en = 1'b1; ex_fwd_addr = 5'd5; ex_fwd_data = 32'hAA;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hBB;
    issue(5'd5, 5'd6, 5'd2, 1'b1, 1'b0, 32'h1, 6'd1, 32'h11, 32'h22, 32'hAA, 32'h22);
    ex_fwd_addr = 5'd0; wb_addr = 5'd0;
    issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 32'h2, 6'd2, 32'h33, 32'h33, 32'h0, 32'h0);
    ex_fwd_addr = 5'd8; ex_fwd_data = 32'hDD; wb_addr = 5'd9; wb_data = 32'hCC;
    issue(5'd8, 5'd9, 5'd3, 1'b1, 1'b0, 32'h3, 6'd3, 32'h44, 32'h55, 32'hDD, 32'hCC);
    ex_fwd_en = 1'b0; wb_en = 1'b0;

    // Load-use stall then same-cycle WB bypass
    issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h4, 6'd4, 32'd1, 32'd2, 32'd1, 32'd2);
    check("pre_stall_cnt", {96'd0, stall_cnt}, 128'd0);
    set_instr(5'd0, 5'd7, 5'd4, 1'b1, 1'b0, 32'h5, 6'd6, 32'h0, 32'h0);
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {127'd0, in_ready}, 128'd0);
      step();
      check("stall_cnt_inc", {96'd0, stall_cnt}, 128'(i));
    end
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
    @(negedge clk);
    check("wb_release_ready", {127'd0, in_ready}, 128'd1);
    if (in_ready) exp_q.push_back(pack(32'h0, 32'h55, 32'h5, 6'd6, 5'd4, 1'b1, 1'b0));
    step();
    in_valid = 1'b0; wb_en = 1'b0; wb_is_load = 1'b0;
    check("wb_stall_hold", {96'd0, stall_cnt}, 128'd3);
    issue(5'd7, 5'd0, 5'd5, 1'b1, 1'b0, 32'h6, 6'd7, 32'h77, 32'h0, 32'h77, 32'h0);
    idle();

    // Backpressure: held outputs, then back-to-back
    out_ready = 1'b0;
    issue(5'd10, 5'd11, 5'd6, 1'b1, 1'b0, 32'h7, 6'd8, 32'h1010, 32'h1111, 32'h1010, 32'h1111);
    set_instr(5'd12, 5'd13, 5'd6, 1'b1, 1'b0, 32'h8, 6'd9, 32'h1212, 32'h1313);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
      check("bp_valid", {127'd0, out_valid}, 128'd1);
      check("bp_hold", {64'd0, out_a, out_b}, {64'd0, 32'h1010, 32'h1111});
      step();
    end
    out_ready = 1'b1;
    issue(5'd12, 5'd13, 5'd6, 1'b1, 1'b0, 32'h8, 6'd9, 32'h1212, 32'h1313, 32'h1212, 32'h1313);
    issue(5'd14, 5'd15, 5'd8, 1'b1, 1'b0, 32'h9, 6'd10, 32'h1414, 32'h1515, 32'h1414, 32'h1515);
    check("b2b_valid", {127'd0, out_valid}, 128'd1);
    idle();

    // Flush with a pending load on x9
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'hA, 6'd11, 32'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    set_instr(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 32'hB, 6'd12, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    flush = 1'b0;
    check("flush_out_valid", {127'd0, out_valid}, 128'd0);
    check("flush_no_stall_cnt", {96'd0, stall_cnt}, 128'd3);
    void'(exp_q.pop_back());
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_keeps_pending", {127'd0, in_ready}, 128'd0);
    step();
    check("pending9_stall_cnt", {96'd0, stall_cnt}, 128'd4);
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    issue(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 32'hB, 6'd12, 32'h0, 32'h0, 32'h99, 32'h0);
    wb_en = 1'b0; wb_is_load = 1'b0;
    idle();

    // Async reset during a stall
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'hC, 6'd13, 32'h0, 32'h0, 32'h0, 32'h0);
    set_instr(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 32'hD, 6'd14, 32'h1234, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_in_ready", {127'd0, in_ready}, 128'd0);
    step();
    check("pre_rst_stall_cnt", {96'd0, stall_cnt}, 128'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {127'd0, out_valid}, 128'd0);
    check("async_stall_cnt", {96'd0, stall_cnt}, 128'd0);
    check("async_out_a", {96'd0, out_a}, 128'd0);
    check("async_pending_clr", {127'd0, in_ready}, 128'd1);
    void'(exp_q.pop_back());
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 32'hD, 6'd14, 32'h1234, 32'h0, 32'h1234, 32'h0);
    wb_en = 1'b1; wb_is_load = 1'b1; wb_addr = 5'd12; wb_data = 32'h77;
    issue(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 32'hE, 6'd15, 32'h4321, 32'h0, 32'h77, 32'h0);
    wb_en = 1'b0; wb_is_load = 1'b0;
    issue(5'd12, 5'd12, 5'd12, 1'b1, 1'b0, 32'hF, 6'd16, 32'h5, 32'h6, 32'h5, 32'h6);

    idle();
    idle();
    idle();
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
